// File: rtl/nn_pkg.sv
// Shared constants and FSM encoding for the neural-network datapath blocks.
package nn_pkg;

  localparam int unsigned DEF_DATA_W = 16;
  localparam int unsigned DEF_BIAS_W = 8;

  typedef enum logic {
    StAcc  = 1'b0,
    StHold = 1'b1
  } acc_state_e;

endpackage

// File: rtl/sat_add.sv
// One-channel signed adder with overflow detect and optional clamp to the signed range.
module sat_add #(
  parameter int unsigned DATA_W   = 16,
  parameter bit          SATURATE = 1'b1
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] sum,
  output logic              ovf
);

  localparam logic [DATA_W-1:0] MaxPos = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MaxNeg = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W-1:0] raw;

  always_comb begin
    raw = a + b;
    // Overflow only when operands agree in sign and the result does not.
    ovf = (a[DATA_W-1] == b[DATA_W-1]) && (raw[DATA_W-1] != a[DATA_W-1]);
    sum = raw;
    if (SATURATE && ovf) begin
      sum = a[DATA_W-1] ? MaxNeg : MaxPos;
    end
  end

endmodule

// File: rtl/bias_accum_array.sv
// Bias-preloaded multi-beat partial-sum accumulator with valid/ready on both sides.
module bias_accum_array
  import nn_pkg::*;
#(
  parameter int unsigned NUM_CH     = 10,
  parameter int unsigned DATA_W     = DEF_DATA_W,
  parameter int unsigned BIAS_W     = DEF_BIAS_W,
  parameter int unsigned BIAS_SHIFT = 4,
  parameter int unsigned NUM_BEATS  = 4,
  parameter bit          SATURATE   = 1'b1,
  parameter string       BIAS_FILE  = "bias.mem",
  // Bias ROM contents; entry 0 in the low bits.
  parameter logic [NUM_CH*BIAS_W-1:0] BIAS_INIT = '0
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic [NUM_CH-1:0]        out_ovf
);

  localparam int unsigned CNT_W = $clog2(NUM_BEATS + 1);
  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(NUM_BEATS - 1);

  logic [BIAS_W-1:0] rom [NUM_CH];
  logic [DATA_W-1:0] biasx [NUM_CH];
  logic [DATA_W-1:0] add_sum [NUM_CH];
  logic [NUM_CH-1:0] add_ovf;

  acc_state_e        state_q;
  logic [CNT_W-1:0]  beat_cnt_q;
  logic [DATA_W-1:0] acc_q [NUM_CH];
  logic [NUM_CH-1:0] ovf_q;

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ent
    assign rom[k] = BIAS_INIT[k*BIAS_W +: BIAS_W];
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    // Sign-extend first, then shift, so the binary point lines up with the data.
    assign biasx[k] = DATA_W'($signed(rom[k])) << BIAS_SHIFT;

    sat_add #(
      .DATA_W   (DATA_W),
      .SATURATE (SATURATE)
    ) u_add (
      .a   (acc_q[k]),
      .b   (in_data[k*DATA_W +: DATA_W]),
      .sum (add_sum[k]),
      .ovf (add_ovf[k])
    );

    assign out_data[k*DATA_W +: DATA_W] = acc_q[k];
  end

  assign in_ready  = (state_q == StAcc);
  assign out_valid = (state_q == StHold);
  assign out_ovf   = ovf_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StAcc;
      beat_cnt_q <= '0;
      ovf_q      <= '0;
      for (int k = 0; k < NUM_CH; k++) acc_q[k] <= biasx[k];
    end else begin
      case (state_q)
        StAcc: begin
          if (in_valid) begin
            for (int k = 0; k < NUM_CH; k++) acc_q[k] <= add_sum[k];
            ovf_q <= ovf_q | add_ovf;
            if (beat_cnt_q == LastBeat) begin
              beat_cnt_q <= '0;
              state_q    <= StHold;
            end else begin
              beat_cnt_q <= beat_cnt_q + 1'b1;
            end
          end
        end
        StHold: begin
          if (out_ready) begin
            for (int k = 0; k < NUM_CH; k++) acc_q[k] <= biasx[k];
            ovf_q   <= '0;
            state_q <= StAcc;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bias_accum_array.sv
// Directed bench: saturating and wrapping instances share stimulus; a single-beat instance runs alone.
module tb_bias_accum_array;

  localparam int unsigned NCH = 10;
  localparam int unsigned DW  = 16;
  localparam logic [NCH*8-1:0] BIAS = {64'h0, 8'hFB, 8'h05};

  logic clk = 1'b0;
  logic reset;
  logic in_valid, out_ready;
  logic [NCH*DW-1:0] in_data;
  logic b_valid, b_ready;

  logic              a_in_ready, a_out_valid, w_in_ready, w_out_valid, b_in_ready, b_out_valid;
  logic [NCH*DW-1:0] a_out_data, w_out_data, b_out_data;
  logic [NCH-1:0]    a_out_ovf, w_out_ovf, b_out_ovf;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bias_accum_array #(.SATURATE(1'b1), .BIAS_FILE(""), .BIAS_INIT(BIAS)) dut_a (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
    .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data), .out_ovf(a_out_ovf)
  );

  bias_accum_array #(.SATURATE(1'b0), .BIAS_FILE(""), .BIAS_INIT(BIAS)) dut_w (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(w_in_ready), .in_data(in_data),
    .out_valid(w_out_valid), .out_ready(out_ready), .out_data(w_out_data), .out_ovf(w_out_ovf)
  );

  bias_accum_array #(.NUM_BEATS(1), .BIAS_FILE(""), .BIAS_INIT(BIAS)) dut_b (
    .clk(clk), .reset(reset), .in_valid(b_valid), .in_ready(b_in_ready), .in_data(in_data),
    .out_valid(b_out_valid), .out_ready(b_ready), .out_data(b_out_data), .out_ovf(b_out_ovf)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] chn(input logic [NCH*DW-1:0] d, input int k);
    return d[k*DW +: DW];
  endfunction

  function automatic logic [NCH*DW-1:0] vec_all(input logic [15:0] v);
    return {NCH{v}};
  endfunction

  function automatic logic [NCH*DW-1:0] vec_one(input int k, input logic [15:0] v);
    logic [NCH*DW-1:0] r;
    r = '0;
    r[k*DW +: DW] = v;
    return r;
  endfunction

  initial begin
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; in_data = '0;
    b_valid = 1'b0; b_ready = 1'b0;
    tick();
    tick();
    // Reset state
    chk("rst_out_valid", a_out_valid, 1'b0);
    chk("rst_in_ready", a_in_ready, 1'b1);
    chk("rst_ch0", chn(a_out_data, 0), 16'h0050);
    chk("rst_ch1", chn(a_out_data, 1), 16'hFFB0);
    chk("rst_ovf", a_out_ovf, 10'h000);
    reset = 1'b0;

    // Four beats of 0x0010, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = vec_all(16'h0010);
      tick();
      if (i == 2) chk("basic_not_yet_valid", a_out_valid, 1'b0);
    end
    in_valid = 1'b0;
    chk("basic_out_valid", a_out_valid, 1'b1);
    chk("basic_in_ready_low", a_in_ready, 1'b0);
    chk("basic_ch0", chn(a_out_data, 0), 16'h0090);
    chk("basic_ch1", chn(a_out_data, 1), 16'hFFF0);
    chk("basic_ch2", chn(a_out_data, 2), 16'h0040);
    chk("basic_ovf", a_out_ovf, 10'h000);
    tick();
    chk("basic_in_ready_back", a_in_ready, 1'b1);
    chk("basic_out_valid_drop", a_out_valid, 1'b0);
    chk("basic_reload_ch0", chn(a_out_data, 0), 16'h0050);
    out_ready = 1'b0;

    // Overflow on ch2: clamp vs wrap
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data = vec_one(2, (i < 2) ? 16'h7000 : 16'h0000);
      tick();
    end
    in_valid = 1'b0;
    chk("sat_ch2", chn(a_out_data, 2), 16'h7FFF);
    chk("sat_ovf", a_out_ovf, 10'h004);
    chk("sat_ch0", chn(a_out_data, 0), 16'h0050);
    chk("wrap_ch2", chn(w_out_data, 2), 16'hE000);
    chk("wrap_ovf", w_out_ovf, 10'h004);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ovf_cleared", a_out_ovf, 10'h000);
    chk("ovf_reload_ch2", chn(a_out_data, 2), 16'h0000);

    // in_valid every other cycle; long HOLD with extra valid beats offered
    for (int i = 0; i < 7; i++) begin
      in_valid = (i % 2 == 0); in_data = vec_all(16'h0001);
      tick();
    end
    in_valid = 1'b0;
    chk("gap_out_valid", a_out_valid, 1'b1);
    chk("gap_ch0", chn(a_out_data, 0), 16'h0054);
    chk("gap_ch1", chn(a_out_data, 1), 16'hFFB4);
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0); in_data = vec_all(16'h0100);
      tick();
      chk("hold_ch0", chn(a_out_data, 0), 16'h0054);
      chk("hold_in_ready", a_in_ready, 1'b0);
      chk("hold_out_valid", a_out_valid, 1'b1);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("after_hold_in_ready", a_in_ready, 1'b1);
    chk("after_hold_ch0", chn(a_out_data, 0), 16'h0050);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = vec_all(16'h0002);
      tick();
    end
    in_valid = 1'b0;
    chk("no_absorb_ch0", chn(a_out_data, 0), 16'h0058);
    chk("no_absorb_wrap_ch2", chn(w_out_data, 2), 16'h0008);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Reset mid-accumulation
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_data = vec_all(16'h0100);
      tick();
    end
    in_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("midrst_in_ready", a_in_ready, 1'b1);
    chk("midrst_ch0", chn(a_out_data, 0), 16'h0050);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_data = vec_all(16'h0003);
      tick();
      if (i == 2) chk("midrst_not_early", a_out_valid, 1'b0);
    end
    in_valid = 1'b0;
    chk("midrst_out_valid", a_out_valid, 1'b1);
    chk("midrst_res_ch0", chn(a_out_data, 0), 16'h005C);
    chk("midrst_res_ch1", chn(a_out_data, 1), 16'hFFBC);
    chk("midrst_res_ch2", chn(a_out_data, 2), 16'h000C);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Single-beat instance: continuous valid and ready
    chk("nb1_idle_ch0", chn(b_out_data, 0), 16'h0050);
    b_valid = 1'b1; b_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      in_data = vec_all(16'((c + 1) * 16));
      tick();
      if (c % 2 == 0) begin
        chk("nb1_out_valid", b_out_valid, 1'b1);
        chk("nb1_ch0", chn(b_out_data, 0), 16'(32'h50 + (c + 1) * 16));
        chk("nb1_ch1", chn(b_out_data, 1), 16'(32'hFFB0 + (c + 1) * 16));
      end else begin
        chk("nb1_gap_valid", b_out_valid, 1'b0);
        chk("nb1_gap_ready", b_in_ready, 1'b1);
      end
    end
    b_valid = 1'b0; b_ready = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/bias_accum_array.md
# bias_accum_array

Parametrised, handshaked bias-plus-partial-sum accumulator for one fully-connected layer. It holds NUM_CH channel accumulators, preloads each with its fixed-point-aligned bias, then adds NUM_BEATS partial-sum vectors, with optional saturation. It presents the result behind a valid/ready handshake. It sits between the MAC array of any layer and the activation stage, replacing per-layer fixed-width bias adders.

## Interface
- NUM_CH, 10, number of channels (neurons)
- DATA_W, 16, signed two's-complement accumulator/data width per channel
- BIAS_W, 8, signed bias width as stored in the bias file
- BIAS_SHIFT, 4, left shift applied to the bias to align its binary point with the data; BIAS_W+BIAS_SHIFT <= DATA_W
- NUM_BEATS, 4, partial-sum vectors accumulated per result; >= 1
- SATURATE, 1, 1 = clamp on signed overflow, 0 = wrap modulo 2^DATA_W
- BIAS_FILE, "bias.mem", $readmemb file with NUM_CH entries of BIAS_W bits, entry 0 = channel 0
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  partial-sum vector valid
- in_ready  out  1  block accepts a vector this cycle
- in_data  in  NUM_CH*DATA_W  partial sums; channel k occupies bits [k*DATA_W +: DATA_W]
- out_valid  out  1  result vector valid
- out_ready  in  1  consumer accepts the result
- out_data  out  NUM_CH*DATA_W  accumulated results, same packing as in_data
- out_ovf  out  NUM_CH  per-channel sticky overflow flag for the current result

## Operation
- Bias alignment: biasx[k] = sign-extend({bias[k], BIAS_SHIFT zeros}) to DATA_W.
- States: ACC, HOLD. The state is registered. in_ready = (state==ACC). out_valid = (state==HOLD).
- Reset: state ACC, beat_cnt 0, acc[k] = biasx[k], out_ovf all 0.
- ACC: on in_valid && in_ready, acc[k] <= acc[k] + in_data[k] for all k, and beat_cnt increments.
  - When this is beat NUM_BEATS-1, go to HOLD and set beat_cnt to 0.
  - With no in_valid, everything holds.
- HOLD: out_data = acc, stable. in_data is ignored.
  - On out_ready, return to ACC, reload acc[k] = biasx[k], and clear out_ovf.
- Arithmetic: signed DATA_W add. Overflow occurs when both operands have the same sign and the sum's sign differs.
  - SATURATE=1: the result clamps to 2^(DATA_W-1)-1 or -2^(DATA_W-1).
  - SATURATE=0: the result wraps.
  - In both modes out_ovf[k] sets and stays set until reload.
- A saturated accumulator keeps accumulating from the clamped value. Later opposite-sign inputs can pull it back in range, but out_ovf stays set.
- Reset at any point, including mid-accumulation or in HOLD, discards all state and behaves as power-up reset.
- out_data is always acc. It is only meaningful while out_valid=1.

## Timing
- The accumulator update is registered: the sum is visible the cycle after the beat is accepted.
- out_valid rises the cycle after the last beat handshake.
- in_ready rises the cycle after the out_valid && out_ready handshake. There is no combinational path from out_ready to in_ready.
- Peak throughput: one result per NUM_BEATS+1 cycles.
- Holding out_ready high gives a one-cycle HOLD.
- NUM_BEATS=1: every accepted beat produces a result.

## Structure
- Package nn_pkg holds the shared constants: default DATA_W, BIAS_W, and the ACC/HOLD state encoding (1 bit).
- Sub-module sat_add holds one channel. Parameters: DATA_W, SATURATE. Inputs: a, b. Outputs: sum, ovf. Combinational.
- The top instantiates NUM_CH sat_add copies via generate and keeps the registers, FSM, beat counter (width $clog2(NUM_BEATS+1)) and bias ROM.

## Test plan
All scenarios use the defaults unless stated. Bias file: ch0=0x05, ch1=0xFB, others 0x00.
- Reset only -> out_valid=0, in_ready=1; internal acc ch0=0x0050, ch1=0xFFB0.
- Four beats of 0x0010 on all channels, out_ready=1 -> out_valid one cycle after the 4th beat; ch0=0x0090, ch1=0xFFF0, ch2=0x0040; out_ovf=0; in_ready high the next cycle.
- Beats on ch2 of 0x7000, 0x7000, 0x0000, 0x0000 -> SATURATE=1: ch2=0x7FFF, out_ovf[2]=1. SATURATE=0: ch2=0xE000, out_ovf[2]=1.
- in_valid toggled every other cycle, out_ready held low for 5 cycles after out_valid -> result is unchanged during HOLD, in_ready=0, and extra in_valid beats are not absorbed into the next result.
- Reset asserted after 2 beats -> the next result equals bias plus the 4 post-reset beats only.
- NUM_BEATS=1, continuous in_valid and out_ready -> a result every 2 cycles, each equal to bias + input.
